// File: rtl/jt900h_blkseq.sv
// jt900h_blkseq: block-transfer sequencer for the TLCS-900H core.
//
// Runs LDI/LDD/LDIR/LDDR and CPI/CPD/CPIR/CPDR. Each iteration is one memory
// read, then one write (LD) or one compare (CP), then a single update cycle
// that pulses the pointer and counter strobes to the register file.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   cen_i              clock enable; state and registered outputs advance only when high
//   start_i            begin an operation (sampled in IDLE only)
//   op_cp_i            0 = LD family, 1 = CP family
//   dir_dec_i          0 = increment pointers, 1 = decrement
//   rep_i              repeat until BC = 0 (or a match for CP)
//   wide_i             0 = byte, 1 = word
//   bc_unity_i         registered BC == 1 from the register file
//   irq_pend_i         interrupt pending, checked between repeat iterations
//   cmp_val_i          A / WA compare value for CP
//   rd_data_i          memory read data
//   mem_ack_i          completes the current rd_req_o / wr_req_o
//   rd_req_o, wr_req_o bus requests (decoded from the current state)
//   wr_data_o          latched read data, upper byte zeroed in byte mode
//   reg_step_o         register-file step code, {1'b0, wide}
//   src_inc_o, src_dec_o, dst_inc_o, dst_dec_o, dec_bc_o
//                      one-cycle update strobes, gated by cen_i
//   busy_o             high in every state except IDLE
//   done_o             completion pulse
//   restart_o          valid with done_o; repeat was interrupted
//   flag_v_o, flag_z_o V and Z results, valid from done_o until the next start

module jt900h_blkseq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    input  logic        start_i,
    input  logic        op_cp_i,
    input  logic        dir_dec_i,
    input  logic        rep_i,
    input  logic        wide_i,
    input  logic        bc_unity_i,
    input  logic        irq_pend_i,
    input  logic [15:0] cmp_val_i,
    input  logic [15:0] rd_data_i,
    input  logic        mem_ack_i,
    output logic        rd_req_o,
    output logic        wr_req_o,
    output logic [15:0] wr_data_o,
    output logic [1:0]  reg_step_o,
    output logic        src_inc_o,
    output logic        src_dec_o,
    output logic        dst_inc_o,
    output logic        dst_dec_o,
    output logic        dec_bc_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        restart_o,
    output logic        flag_v_o,
    output logic        flag_z_o
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STEP_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_CMP,
        ST_UPD,
        ST_FIN
    } state_t;

    state_t              state_q;

    // Operation descriptor captured at start
    logic                op_cp_q;
    logic                dir_dec_q;
    logic                rep_q;
    logic                wide_q;

    logic [DATA_W-1:0]   wr_data_q;
    logic [STEP_W-1:0]   reg_step_q;
    logic                match_q;
    logic                busy_q;
    logic                done_q;
    logic                restart_q;
    logic                flag_v_q;
    logic                flag_z_q;

    logic [DATA_W-1:0]   rd_data_d;
    logic [DATA_W-1:0]   cmp_val_d;
    logic                match_d;
    logic                fin_d;
    logic                upd_en;

    // Width-masked read data and compare operand
    assign rd_data_d = wide_q ? rd_data_i
                              : {BYTE_W'(0), rd_data_i[BYTE_W-1:0]};
    assign cmp_val_d = wide_q ? cmp_val_i
                              : {BYTE_W'(0), cmp_val_i[BYTE_W-1:0]};
    assign match_d   = (wr_data_q == cmp_val_d);

    // Loop terminates on single pass, last count, or a CP match
    assign fin_d     = ~rep_q | bc_unity_i | (op_cp_q & match_q);

    // Strobes fire once per UPD: only on the enabled cycle
    assign upd_en    = cen_i & (state_q == ST_UPD);

    assign rd_req_o  = (state_q == ST_RD);
    assign wr_req_o  = (state_q == ST_WR);

    assign dec_bc_o  = upd_en;
    assign src_inc_o = upd_en & ~dir_dec_q;
    assign src_dec_o = upd_en &  dir_dec_q;
    assign dst_inc_o = upd_en & ~op_cp_q & ~dir_dec_q;
    assign dst_dec_o = upd_en & ~op_cp_q &  dir_dec_q;

    assign wr_data_o  = wr_data_q;
    assign reg_step_o = reg_step_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign restart_o  = restart_q;
    assign flag_v_o   = flag_v_q;
    assign flag_z_o   = flag_z_q;

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_cp_q    <= 1'b0;
            dir_dec_q  <= 1'b0;
            rep_q      <= 1'b0;
            wide_q     <= 1'b0;
            wr_data_q  <= DATA_W'(0);
            reg_step_q <= STEP_W'(0);
            match_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            restart_q  <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_z_q   <= 1'b0;
        end else if (cen_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_cp_q    <= op_cp_i;
                        dir_dec_q  <= dir_dec_i;
                        rep_q      <= rep_i;
                        wide_q     <= wide_i;
                        reg_step_q <= {1'b0, wide_i};
                        busy_q     <= 1'b1;
                        state_q    <= ST_RD;
                    end
                end

                ST_RD: begin
                    if (mem_ack_i) begin
                        wr_data_q <= rd_data_d;
                        state_q   <= op_cp_q ? ST_CMP : ST_WR;
                    end
                end

                ST_WR: begin
                    if (mem_ack_i) begin
                        state_q <= ST_UPD;
                    end
                end

                ST_CMP: begin
                    match_q <= match_d;
                    state_q <= ST_UPD;
                end

                // bc_unity_i still reflects BC before this cycle's decrement
                ST_UPD: begin
                    flag_v_q <= ~bc_unity_i;
                    if (op_cp_q) begin
                        flag_z_q <= match_q;
                    end
                    if (fin_d) begin
                        done_q    <= 1'b1;
                        restart_q <= 1'b0;
                        state_q   <= ST_FIN;
                    end else if (irq_pend_i) begin
                        done_q    <= 1'b1;
                        restart_q <= 1'b1;
                        state_q   <= ST_FIN;
                    end else begin
                        state_q <= ST_RD;
                    end
                end

                ST_FIN: begin
                    done_q    <= 1'b0;
                    restart_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    done_q    <= 1'b0;
                    restart_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_blkseq.sv
// Self-checking bench for jt900h_blkseq with a small memory / register-file model.
module tb_jt900h_blkseq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        start = 1'b0;
    logic        op_cp = 1'b0;
    logic        dir_dec = 1'b0;
    logic        rep = 1'b0;
    logic        wide = 1'b0;
    logic        bc_unity;
    logic        irq = 1'b0;
    logic [15:0] cmp_val = 16'h0;
    logic [15:0] rd_data = 16'h0;
    logic        mem_ack = 1'b0;

    logic        rd_req, wr_req;
    logic [15:0] wr_data;
    logic [1:0]  reg_step;
    logic        src_inc, src_dec, dst_inc, dst_dec, dec_bc;
    logic        busy, done, restart, flag_v, flag_z;

    jt900h_blkseq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cen_i      (cen),
        .start_i    (start),
        .op_cp_i    (op_cp),
        .dir_dec_i  (dir_dec),
        .rep_i      (rep),
        .wide_i     (wide),
        .bc_unity_i (bc_unity),
        .irq_pend_i (irq),
        .cmp_val_i  (cmp_val),
        .rd_data_i  (rd_data),
        .mem_ack_i  (mem_ack),
        .rd_req_o   (rd_req),
        .wr_req_o   (wr_req),
        .wr_data_o  (wr_data),
        .reg_step_o (reg_step),
        .src_inc_o  (src_inc),
        .src_dec_o  (src_dec),
        .dst_inc_o  (dst_inc),
        .dst_dec_o  (dst_dec),
        .dec_bc_o   (dec_bc),
        .busy_o     (busy),
        .done_o     (done),
        .restart_o  (restart),
        .flag_v_o   (flag_v),
        .flag_z_o   (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        v;
        logic        z;
        logic        rs;
        logic [15:0] wd;
        logic [1:0]  step;
        int          n_dec, n_si, n_sd, n_di, n_dd, n_rd;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          n_done = 0;
    logic        done_prev = 1'b0;

    // Register-file and memory model state
    logic [15:0] bc = 16'h0;
    logic        dec_pend = 1'b0;
    logic [15:0] mem [0:7];
    int          idx = 0;
    int          wait_cnt = 0;
    int          w_rd = 0;
    logic        cen_tog = 1'b0;
    logic        model_z = 1'b0;

    int n_dec = 0, n_si = 0, n_sd = 0, n_di = 0, n_dd = 0, n_rd = 0;

    assign bc_unity = (bc == 16'd1);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder, BC register model, strobe counters and scoreboard
    always @(negedge clk) begin
        cyc++;
        if (dec_pend) begin
            bc       = bc - 16'd1;
            dec_pend = 1'b0;
        end
        cen = cen_tog ? ~cen : 1'b1;
        if (rd_req || wr_req) begin
            if (cen) begin
                if (wait_cnt >= (rd_req ? w_rd : 0)) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (rd_req) begin
                        rd_data = mem[idx];
                        idx     = (idx + 1) % 8;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        #3;
        if (dec_bc) begin
            n_dec++;
            dec_pend = 1'b1;
        end
        if (src_inc) n_si++;
        if (src_dec) n_sd++;
        if (dst_inc) n_di++;
        if (dst_dec) n_dd++;
        if (rd_req && cen) n_rd++;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.lat >= 0) check_val("done_lat", 32'(cyc - start_cyc), 32'(mon_e.lat));
                check_val("flag_v",   32'(flag_v),   32'(mon_e.v));
                check_val("flag_z",   32'(flag_z),   32'(mon_e.z));
                check_val("restart",  32'(restart),  32'(mon_e.rs));
                check_val("wr_data",  32'(wr_data),  32'(mon_e.wd));
                check_val("reg_step", 32'(reg_step), 32'(mon_e.step));
                check_val("n_dec_bc", 32'(n_dec),    32'(mon_e.n_dec));
                check_val("n_src_inc", 32'(n_si),    32'(mon_e.n_si));
                check_val("n_src_dec", 32'(n_sd),    32'(mon_e.n_sd));
                check_val("n_dst_inc", 32'(n_di),    32'(mon_e.n_di));
                check_val("n_dst_dec", 32'(n_dd),    32'(mon_e.n_dd));
                check_val("n_rd_cyc", 32'(n_rd),     32'(mon_e.n_rd));
            end
            n_done++;
        end
        done_prev = done;
    end

    task automatic check_all_zero(input string tag);
        check_val(tag, 32'({rd_req, wr_req, wr_data, reg_step, src_inc, src_dec,
                            dst_inc, dst_dec, dec_bc, busy, done, restart,
                            flag_v, flag_z}), 32'd0);
    endtask

    task automatic run_op(input logic cp, input logic d, input logic r, input logic w,
                          input logic [15:0] bc0, input logic irq_v, input int wrd,
                          input logic ctog, input logic [15:0] cmpv, input logic extra);
        exp_t        e;
        logic [15:0] b, dat, cm;
        logic        m, fin;
        int          it;
        int          target;
        @(negedge clk); #1;
        op_cp = cp; dir_dec = d; rep = r; wide = w;
        bc = bc0; idx = 0; w_rd = wrd; irq = irq_v; cmp_val = cmpv;
        n_dec = 0; n_si = 0; n_sd = 0; n_di = 0; n_dd = 0; n_rd = 0;
        // Reference model of the iteration loop
        b = bc0; it = 0; dat = 16'h0;
        e.v = 1'b0; e.z = model_z; e.rs = 1'b0;
        cm = w ? cmpv : {8'h00, cmpv[7:0]};
        for (int k = 0; k < 16; k++) begin
            dat = mem[it % 8];
            if (!w) dat = {8'h00, dat[7:0]};
            it++;
            m   = (dat == cm);
            e.v = (b != 16'd1);
            if (cp) e.z = m;
            fin = !r || (b == 16'd1) || (cp && m);
            b   = b - 16'd1;
            if (fin) break;
            if (irq_v) begin
                e.rs = 1'b1;
                break;
            end
        end
        model_z = e.z;
        e.wd    = dat;
        e.step  = {1'b0, w};
        e.n_dec = it;
        e.n_si  = d ? 0 : it;
        e.n_sd  = d ? it : 0;
        e.n_di  = (cp || d) ? 0 : it;
        e.n_dd  = (!cp && d) ? it : 0;
        e.n_rd  = it * (1 + wrd);
        e.lat   = ctog ? -1 : 1 + it * (3 + wrd);
        sb_q.push_back(e);
        target    = n_done + 1;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start   = 1'b0;
        cen_tog = ctog;
        if (extra) begin
            @(negedge clk); #1;
            start = 1'b1; op_cp = ~cp;
            @(negedge clk); #1;
            start = 1'b0; op_cp = cp;
        end
        for (int k = 0; k < 300 && n_done < target; k++) @(negedge clk);
        if (n_done < target) begin
            check_val("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        cen_tog = 1'b0;
        irq     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;

        // LDI byte, BC=3: upper byte of read data is masked
        mem[0] = 16'hA55A;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 0, 1'b0, 16'h0, 1'b0);

        // LDDR word, BC=2
        mem[0] = 16'h1234; mem[1] = 16'hBEEF;
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 0, 1'b0, 16'h0, 1'b0);

        // CPIR byte, A=0x33 (upper compare byte masked), match on 2nd
        mem[0] = 16'h4411; mem[1] = 16'h5533; mem[2] = 16'h0033;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 0, 1'b0, 16'hFF33, 1'b0);

        // Reset while in WR aborts immediately
        @(negedge clk); #1;
        op_cp = 1'b0; dir_dec = 1'b0; rep = 1'b1; wide = 1'b1;
        bc = 16'd5; idx = 0; mem[0] = 16'hC3C3; n_dec = 0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check_val("in_wr_state", 32'(wr_req), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check_all_zero("reset_in_wr");
        model_z = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("no_strobe_after_rst", 32'(n_dec), 32'd0);
        check_val("idle_after_rst", 32'(busy), 32'd0);

        // LDIR BC=4 interrupted after the first iteration
        mem[0] = 16'h0077; mem[1] = 16'h0088;
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 0, 1'b0, 16'h0, 1'b0);

        // Three read wait states, BC=1 single iteration
        mem[0] = 16'h9ABC;
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 3, 1'b0, 16'h0, 1'b0);

        // cen toggling: each strobe fires once
        mem[0] = 16'h00E1;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 0, 1'b1, 16'h0, 1'b0);

        // CPD word, no match
        mem[0] = 16'h1235;
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 0, 1'b0, 16'h1234, 1'b0);

        // CPDR word runs out of count without a match
        mem[0] = 16'hAAAA; mem[1] = 16'hBBBB; mem[2] = 16'hCCCC;
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 0, 1'b0, 16'h1234, 1'b0);

        // Start pulsed while busy (with op_cp flipped) is ignored
        mem[0] = 16'h0042; mem[1] = 16'h0043;
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 0, 1'b0, 16'h0042, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check_val("idle_after_extra_start", 32'(busy), 32'd0);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
